// File: rtl/pdp8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pdp8_mem_arbiter
//
// Shares the single PDP8 memory port between the instruction-fetch read port
// and the execute unit's read and write ports. One memory operation is in
// flight at a time. Read data is steered back to whichever requester owns the
// outstanding read.
//
// Configuration macro: PDP8_ARB_RR_EN
//   defined   -> round-robin among {exec_wr, exec_rd, ifu_rd}; the requester
//                granted last becomes lowest priority.
//   undefined -> fixed priority exec_wr > exec_rd > ifu_rd.
//
// Parameters
//   ADDR_WIDTH  address width
//   DATA_WIDTH  data width
//   RD_LATENCY  cycles from a read mem_req to valid mem_rdata (1..7)
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   ifu_rd_req/addr                   IFU read request (level, held to gnt)
//   ifu_gnt, ifu_rd_valid/data        IFU grant pulse, read-data pulse/data
//   exec_rd_req/addr                  EXEC read request (level)
//   exec_rd_gnt, exec_rd_valid/data   EXEC read grant, read-data pulse/data
//   exec_wr_req/addr/data             EXEC write request (level)
//   exec_wr_gnt                       pulse when the write goes to memory
//   mem_req/we/addr/wdata             memory op strobe and operands
//   mem_rdata                         memory read data
//   arb_err                           pulse: exec read and write collided
//
// Every output is a flop. The combinational block computes the value each
// output takes in the next state, so e.g. a grant is visible during ISSUE.
// -----------------------------------------------------------------------------
module pdp8_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rd_valid,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic                  exec_rd_gnt,
    output logic                  exec_rd_valid,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  exec_wr_gnt,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  arb_err
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OWN_WR, OWN_RD, OWN_IFU} owner_t;

    state_t             state, state_nx;
    owner_t             owner, owner_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    logic                  ifu_gnt_nx, exec_rd_gnt_nx, exec_wr_gnt_nx;
    logic                  ifu_rd_valid_nx, exec_rd_valid_nx;
    logic [DATA_WIDTH-1:0] ifu_rd_data_nx, exec_rd_data_nx;
    logic                  mem_req_nx, mem_we_nx, arb_err_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic [DATA_WIDTH-1:0] mem_wdata_nx;

    logic   any_req;
    owner_t win;

`ifdef PDP8_ARB_RR_EN
    // rr_ptr names the requester that currently has the highest priority.
    owner_t rr_ptr, rr_ptr_nx;

    function automatic owner_t pick_rr(input logic wr, input logic rd,
                                       input logic ifu, input owner_t ptr);
        owner_t w;
        w = OWN_WR;
        case (ptr)
            OWN_WR:  w = wr  ? OWN_WR  : (rd  ? OWN_RD  : OWN_IFU);
            OWN_RD:  w = rd  ? OWN_RD  : (ifu ? OWN_IFU : OWN_WR);
            default: w = ifu ? OWN_IFU : (wr  ? OWN_WR  : OWN_RD);
        endcase
        return w;
    endfunction

    function automatic owner_t after(input owner_t o);
        owner_t n;
        case (o)
            OWN_WR:  n = OWN_RD;
            OWN_RD:  n = OWN_IFU;
            default: n = OWN_WR;
        endcase
        return n;
    endfunction
`else
    // Only called when some request is high, so "neither exec" means IFU.
    function automatic owner_t pick_fixed(input logic wr, input logic rd);
        return wr ? OWN_WR : (rd ? OWN_RD : OWN_IFU);
    endfunction
`endif

    always_comb begin
        state_nx         = state;
        owner_nx         = owner;
        cnt_nx           = cnt;
        ifu_gnt_nx       = 1'b0;
        exec_rd_gnt_nx   = 1'b0;
        exec_wr_gnt_nx   = 1'b0;
        ifu_rd_valid_nx  = 1'b0;
        exec_rd_valid_nx = 1'b0;
        ifu_rd_data_nx   = ifu_rd_data;
        exec_rd_data_nx  = exec_rd_data;
        mem_req_nx       = 1'b0;
        mem_we_nx        = 1'b0;
        mem_addr_nx      = mem_addr;
        mem_wdata_nx     = mem_wdata;
        arb_err_nx       = 1'b0;
        any_req          = ifu_rd_req | exec_rd_req | exec_wr_req;
`ifdef PDP8_ARB_RR_EN
        rr_ptr_nx        = rr_ptr;
        win              = pick_rr(exec_wr_req, exec_rd_req, ifu_rd_req, rr_ptr);
`else
        win              = pick_fixed(exec_wr_req, exec_rd_req);
`endif

        case (state)
            // RESP shares the arbitration path with IDLE so a new op can be
            // issued immediately after a read response.
            IDLE, RESP: begin
                state_nx = IDLE;
                if (any_req) begin
                    state_nx   = ISSUE;
                    owner_nx   = win;
                    mem_req_nx = 1'b1;
                    arb_err_nx = exec_rd_req & exec_wr_req;
                    case (win)
                        OWN_WR: begin
                            mem_we_nx      = 1'b1;
                            mem_addr_nx    = exec_wr_addr;
                            mem_wdata_nx   = exec_wr_data;
                            exec_wr_gnt_nx = 1'b1;
                        end
                        OWN_RD: begin
                            mem_addr_nx    = exec_rd_addr;
                            exec_rd_gnt_nx = 1'b1;
                        end
                        default: begin
                            mem_addr_nx    = ifu_rd_addr;
                            ifu_gnt_nx     = 1'b1;
                        end
                    endcase
`ifdef PDP8_ARB_RR_EN
                    rr_ptr_nx = after(win);
`endif
                end
            end

            ISSUE: begin
                if (owner == OWN_WR) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_W'(RD_LATENCY - 1);
                end
            end

            // The cycle in which cnt reaches zero is the one where mem_rdata
            // is valid; it is written straight into the owner's data register.
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                    if (owner == OWN_RD) begin
                        exec_rd_valid_nx = 1'b1;
                        exec_rd_data_nx  = mem_rdata;
                    end else begin
                        ifu_rd_valid_nx  = 1'b1;
                        ifu_rd_data_nx   = mem_rdata;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= OWN_WR;
            cnt           <= '0;
            ifu_gnt       <= 1'b0;
            exec_rd_gnt   <= 1'b0;
            exec_wr_gnt   <= 1'b0;
            ifu_rd_valid  <= 1'b0;
            exec_rd_valid <= 1'b0;
            ifu_rd_data   <= '0;
            exec_rd_data  <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            arb_err       <= 1'b0;
`ifdef PDP8_ARB_RR_EN
            rr_ptr        <= OWN_WR;
`endif
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            cnt           <= cnt_nx;
            ifu_gnt       <= ifu_gnt_nx;
            exec_rd_gnt   <= exec_rd_gnt_nx;
            exec_wr_gnt   <= exec_wr_gnt_nx;
            ifu_rd_valid  <= ifu_rd_valid_nx;
            exec_rd_valid <= exec_rd_valid_nx;
            ifu_rd_data   <= ifu_rd_data_nx;
            exec_rd_data  <= exec_rd_data_nx;
            mem_req       <= mem_req_nx;
            mem_we        <= mem_we_nx;
            mem_addr      <= mem_addr_nx;
            mem_wdata     <= mem_wdata_nx;
            arb_err       <= arb_err_nx;
`ifdef PDP8_ARB_RR_EN
            rr_ptr        <= rr_ptr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pdp8_mem_arbiter
//
// Scoreboard bench for pdp8_mem_arbiter (fixed-priority build). Requester
// tasks drive level requests; a memory model answers reads RD_LATENCY cycles
// after mem_req. On every grant the monitor checks the memory op and pushes
// the expected read response (data from a reference memory, due cycle) into a
// per-owner queue; responses are popped and compared when *_rd_valid appears.
// -----------------------------------------------------------------------------
module tb_pdp8_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ifu_rd_req = 1'b0;
    logic [AW-1:0] ifu_rd_addr = '0;
    logic          ifu_gnt, ifu_rd_valid;
    logic [DW-1:0] ifu_rd_data;
    logic          exec_rd_req = 1'b0;
    logic [AW-1:0] exec_rd_addr = '0;
    logic          exec_rd_gnt, exec_rd_valid;
    logic [DW-1:0] exec_rd_data;
    logic          exec_wr_req = 1'b0;
    logic [AW-1:0] exec_wr_addr = '0;
    logic [DW-1:0] exec_wr_data = '0;
    logic          exec_wr_gnt;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          arb_err;

    always #5 clk = ~clk;

    pdp8_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_gnt(ifu_gnt),
        .ifu_rd_valid(ifu_rd_valid), .ifu_rd_data(ifu_rd_data),
        .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_gnt(exec_rd_gnt),
        .exec_rd_valid(exec_rd_valid), .exec_rd_data(exec_rd_data),
        .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
        .exec_wr_gnt(exec_wr_gnt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = DW'(a) * 12'd37;
        return t ^ 12'o5252;
    endfunction

    // ---------------- memory model ----------------
    logic [DW-1:0] mem_arr [0:4095];
    bit            mem_wr  [0:4095];
    logic [DW-1:0] rd_pipe [L];
    int            cyc = 0;
    logic [2:0]    req_edge = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_edge <= {exec_wr_req, exec_rd_req, ifu_rd_req};
        if (mem_req && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_wr[mem_addr]  <= 1'b1;
        end
        // Outside a read response the bus carries junk, so mis-timed capture shows.
        if (mem_req && !mem_we)
            rd_pipe[0] <= mem_wr[mem_addr] ? mem_arr[mem_addr] : init_pat(mem_addr);
        else
            rd_pipe[0] <= DW'($urandom);
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[L-1];

    // ---------------- scoreboard / monitor ----------------
    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t          ifu_q[$];
    exp_t          erd_q[$];
    logic [DW-1:0] ref_mem [0:4095];
    bit            ref_wr  [0:4095];
    logic [DW-1:0] last_ifu = '0, last_erd = '0;
    int ifu_valid_cnt = 0, arb_err_cnt = 0;
    int last_wr_gnt_cyc = 0, last_ifu_gnt_cyc = 0, last_erd_gnt_cyc = 0, last_ifu_valid_cyc = 0;

    always @(negedge clk) begin
        int g;
        exp_t e;
        logic [2:0] wexp;
        logic [AW-1:0] a;
        if (!reset_n) begin
            ifu_q.delete();
            erd_q.delete();
            last_ifu = '0;
            last_erd = '0;
        end else begin
            g = int'(ifu_gnt) + int'(exec_rd_gnt) + int'(exec_wr_gnt);
            if (g > 1) begin
                check("single_gnt", g, 1);
            end else if (g == 1) begin
                check("mem_req_with_gnt", mem_req, 1'b1);
                wexp = req_edge[2] ? 3'b100 : (req_edge[1] ? 3'b010 : 3'b001);
                check("priority", {exec_wr_gnt, exec_rd_gnt, ifu_gnt}, wexp);
                check("arb_err", arb_err, req_edge[2] & req_edge[1]);
                if (arb_err) arb_err_cnt++;
                if (exec_wr_gnt) begin
                    check("wr_we", mem_we, 1'b1);
                    check("wr_addr", mem_addr, exec_wr_addr);
                    check("wr_data", mem_wdata, exec_wr_data);
                    ref_mem[exec_wr_addr] = exec_wr_data;
                    ref_wr[exec_wr_addr]  = 1'b1;
                    last_wr_gnt_cyc = cyc;
                end else begin
                    a = exec_rd_gnt ? exec_rd_addr : ifu_rd_addr;
                    check("rd_we", mem_we, 1'b0);
                    check("rd_addr", mem_addr, a);
                    e.data = ref_wr[a] ? ref_mem[a] : init_pat(a);
                    e.due  = cyc + L + 1;
                    if (exec_rd_gnt) begin
                        erd_q.push_back(e);
                        last_erd_gnt_cyc = cyc;
                    end else begin
                        ifu_q.push_back(e);
                        last_ifu_gnt_cyc = cyc;
                    end
                end
            end else begin
                check("idle_mem_req", mem_req, 1'b0);
                check("idle_arb_err", arb_err, 1'b0);
            end

            if (ifu_rd_valid) begin
                ifu_valid_cnt++;
                last_ifu_valid_cyc = cyc;
                if (ifu_q.size() == 0) begin
                    check("ifu_unexpected_valid", ifu_rd_valid, 1'b0);
                end else begin
                    e = ifu_q.pop_front();
                    check("ifu_data", ifu_rd_data, e.data);
                    check("ifu_latency", cyc, e.due);
                end
                last_ifu = ifu_rd_data;
            end else begin
                check("ifu_data_hold", ifu_rd_data, last_ifu);
            end

            if (exec_rd_valid) begin
                if (erd_q.size() == 0) begin
                    check("erd_unexpected_valid", exec_rd_valid, 1'b0);
                end else begin
                    e = erd_q.pop_front();
                    check("erd_data", exec_rd_data, e.data);
                    check("erd_latency", cyc, e.due);
                end
                last_erd = exec_rd_data;
            end else begin
                check("erd_data_hold", exec_rd_data, last_erd);
            end
        end
    end

    // ---------------- requester drivers ----------------
    // Each task is entered just after a rising edge, holds its request until
    // the grant is seen, then drops it one edge later.
    task automatic do_ifu(input logic [AW-1:0] a);
        int n = 0;
        ifu_rd_addr = a;
        ifu_rd_req  = 1'b1;
        do begin @(negedge clk); n++; end while (!ifu_gnt && n < 400);
        if (!ifu_gnt) check("ifu_gnt_timeout", ifu_gnt, 1'b1);
        @(posedge clk); #1;
        ifu_rd_req = 1'b0;
    endtask

    task automatic do_erd(input logic [AW-1:0] a);
        int n = 0;
        exec_rd_addr = a;
        exec_rd_req  = 1'b1;
        do begin @(negedge clk); n++; end while (!exec_rd_gnt && n < 400);
        if (!exec_rd_gnt) check("erd_gnt_timeout", exec_rd_gnt, 1'b1);
        @(posedge clk); #1;
        exec_rd_req = 1'b0;
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        exec_wr_addr = a;
        exec_wr_data = d;
        exec_wr_req  = 1'b1;
        do begin @(negedge clk); n++; end while (!exec_wr_gnt && n < 400);
        if (!exec_wr_gnt) check("wr_gnt_timeout", exec_wr_gnt, 1'b1);
        @(posedge clk); #1;
        exec_wr_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {ifu_gnt, ifu_rd_valid, exec_rd_gnt, exec_rd_valid,
                               exec_wr_gnt, mem_req, mem_we, arb_err}, 8'h00);
        check({tag, "_ifu_data"}, ifu_rd_data, 12'o0000);
        check({tag, "_erd_data"}, exec_rd_data, 12'o0000);
        check({tag, "_mem_addr"}, mem_addr, 12'o0000);
        check({tag, "_mem_wdata"}, mem_wdata, 12'o0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0, ac0;
        // Power-on reset
        idle_cycles(3);
        check_zero("por");
        reset_n = 1'b1;
        idle_cycles(2);

        // IFU read of 0200 after the location is written with 7402
        do_wr(12'o0200, 12'o7402);
        vc0 = ifu_valid_cnt;
        do_ifu(12'o0200);
        idle_cycles(8);
        check("t2_one_pulse", ifu_valid_cnt - vc0, 1);
        check("t2_data", ifu_rd_data, 12'o7402);

        // Write and IFU read raised together: write first, IFU two cycles later
        fork
            do_wr(12'o0050, 12'o1234);
            do_ifu(12'o0010);
        join
        check("t3_ifu_after_wr", last_ifu_gnt_cyc - last_wr_gnt_cyc, 2);
        idle_cycles(8);

        // Exec read/write collision: write wins, arb_err once, read next
        ac0 = arb_err_cnt;
        fork
            do_wr(12'o0051, 12'o4321);
            do_erd(12'o0051);
        join
        check("t4_arb_err_once", arb_err_cnt - ac0, 1);
        check("t4_rd_after_wr", last_erd_gnt_cyc - last_wr_gnt_cyc, 2);
        idle_cycles(8);
        check("t4_rd_data", exec_rd_data, 12'o4321);

        // EXEC read raised during IFU WAIT is granted from RESP
        fork
            do_ifu(12'o0050);
            begin
                idle_cycles(2);
                do_erd(12'o0200);
            end
        join
        check("t6_resp_grant", last_erd_gnt_cyc - last_ifu_valid_cyc, 1);
        idle_cycles(8);

        // Reset in the middle of an IFU read
        ifu_rd_addr = 12'o0300;
        ifu_rd_req  = 1'b1;
        idle_cycles(2);
        ifu_rd_req = 1'b0;
        reset_n    = 1'b0;
        #1;
        check_zero("midrst");
        idle_cycles(2);
        vc0 = ifu_valid_cnt;
        reset_n = 1'b1;
        idle_cycles(10);
        check("midrst_no_valid", ifu_valid_cnt - vc0, 0);

        // Randomized traffic on all three ports over a small address window
        fork
            for (int i = 0; i < 40; i++) begin
                do_ifu(AW'($urandom_range(0, 15)));
                idle_cycles($urandom_range(1, 6));
            end
            for (int j = 0; j < 30; j++) begin
                do_erd(AW'($urandom_range(0, 15)));
                idle_cycles($urandom_range(1, 6));
            end
            for (int k = 0; k < 30; k++) begin
                do_wr(AW'($urandom_range(0, 15)), DW'($urandom));
                idle_cycles($urandom_range(1, 6));
            end
        join
        idle_cycles(20);
        check("ifu_q_drained", ifu_q.size(), 0);
        check("erd_q_drained", erd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
